pit_cfg_ctrl: RTL and testbench
===============================

PIT_CFG_CTRL -- requirements
Module: pit_cfg_ctrl

Interface
REQ-001 SHALL have parameter STROBE_CYC, default 2, width of the wr_n/rd_n low pulse in zclk cycles (legal 2..15).
REQ-002 SHALL have parameter GAP_CYC, default 1, number of zclk cycles with pit_cs_n high between bus cycles (legal 1..15).
REQ-003 SHALL have port zclk  in  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assertion, active-low.
REQ-005 SHALL have port req_valid  in  1  request strobe.
REQ-006 SHALL have port req_ready  out  1  high only in IDLE.
REQ-007 SHALL have port req_op  in  1  0 = program channel, 1 = latch-and-read channel.
REQ-008 SHALL have port req_ch  in  2  target channel 0..2.
REQ-009 SHALL have port req_mode  in  3  counter mode, program op only.
REQ-010 SHALL have port req_count  in  16  reload value, program op only.
REQ-011 SHALL have port rsp_valid  out  1  one-cycle completion pulse.
REQ-012 SHALL have port rsp_err  out  1  qualifies rsp_valid; request rejected.
REQ-013 SHALL have port rsp_data  out  16  readback value; held until next response.
REQ-014 SHALL have ports pit_cs_n, pit_wr_n, pit_rd_n  out  1 each  timer bus strobes, active-low.
REQ-015 SHALL have ports pit_a  out  2 {a1,a0}; pit_dout  out  8; pit_doe  out  1 drive-enable for pit_dout; pit_din  in  8 timer read data.

Function
REQ-016 Request SHALL be accepted on a rising edge with req_valid & req_ready; all req_* fields captured then.
REQ-017 req_ch==3, or program op with req_mode 4..7, SHALL produce no bus activity and rsp_valid=1, rsp_err=1 on the cycle after acceptance.
REQ-018 Program op SHALL issue three writes: control {ch,2'b11,mode,1'b0} at pit_a=3, then count[7:0] at pit_a=ch, then count[15:8] at pit_a=ch.
REQ-019 Readback op SHALL issue write control {ch,2'b00,4'b0000} at pit_a=3, then read at pit_a=ch (LSB), then read at pit_a=ch (MSB).
REQ-020 FSM states: IDLE, SETUP, STROBE, HOLD, GAP, RESP; 2-bit step counter selects bus cycle 0..2.
REQ-021 SETUP (1 cycle): pit_cs_n=0, pit_a/pit_dout valid, strobes high; pit_doe=1 on writes.
REQ-022 STROBE (STROBE_CYC cycles): pit_wr_n=0 for writes or pit_rd_n=0 for reads; address/data stable.
REQ-023 HOLD (1 cycle): strobes high, pit_cs_n=0, address/data stable.
REQ-024 GAP (GAP_CYC cycles): pit_cs_n=1, pit_doe=0; then SETUP of next step, or RESP after step 2.
REQ-025 Read data SHALL be sampled from pit_din on the last STROBE cycle; step 1 -> rsp_data[7:0], step 2 -> rsp_data[15:8].
REQ-026 RESP (1 cycle): rsp_valid=1, rsp_err=0; next state IDLE.
REQ-027 Latency, defaults: rsp_valid SHALL assert 16 cycles after the accepting edge (3 x 5-cycle bus cycles + 1).
REQ-028 pit_wr_n and pit_rd_n SHALL never be low simultaneously; pit_doe SHALL be 0 whenever pit_rd_n=0.
REQ-029 Outside SETUP/STROBE/HOLD, pit_cs_n=1 and pit_a=0.
REQ-030 req_valid while busy SHALL be ignored; no queueing.
REQ-031 Program op SHALL not alter rsp_data.

Reset
REQ-032 rst_n low SHALL immediately force state IDLE, step 0, req_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, pit_cs_n=pit_wr_n=pit_rd_n=1, pit_a=0, pit_dout=0, pit_doe=0.
REQ-033 Reset mid-operation SHALL abort the sequence with no rsp_valid; the first request after release starts at step 0.

Configuration
REQ-034 Macro PIT_READBACK_EN: defined -> readback op per REQ-019/025.
REQ-035 Not defined -> req_op=1 SHALL be rejected per REQ-017 (rsp_err=1, no bus activity), rsp_data SHALL be tied to 0, pit_rd_n SHALL be tied to 1.

Verification
REQ-036 Program ch0 mode3 count 0x1234 -> writes 0x36@3, 0x34@0, 0x12@0; rsp_valid at cycle 16, rsp_err=0.
REQ-037 Program ch2 mode2 count 0x0000 -> writes 0xB4@3, 0x00@2, 0x00@2; timer ch2 then counts from 0xFFFF.
REQ-038 Readback ch1 (PIT_READBACK_EN) after programming 0x00FF mode2 -> write 0x40@3, two reads; rsp_data nonzero and <= 0x00FF.
REQ-039 req_ch=3 or req_mode=5 -> rsp_valid+rsp_err next cycle; pit_cs_n stays 1 throughout.
REQ-040 rst_n low during step-1 STROBE -> all strobes high same cycle, no rsp_valid; new program request completes normally.
REQ-041 req_valid held high while busy -> exactly one request accepted; check REQ-028 on every cycle.

Source files
------------

// File: rtl/pit_cfg_ctrl.sv
// pit_cfg_ctrl
//   Sequencer that programs or reads back one channel of an 8254-style
//   interval timer over its 8-bit strobed bus. A request is taken in IDLE
//   and expanded into three bus cycles (control word, then low byte, then
//   high byte), each framed as SETUP / STROBE / HOLD / GAP. A one-cycle
//   response is returned at the end of the sequence.
//
// Configuration macro:
//   PIT_READBACK_EN  defined     -> req_op=1 latches the channel and reads
//                                   the 16-bit count back into rsp_data.
//                    not defined -> req_op=1 is rejected (rsp_err), rsp_data
//                                   is tied to 0 and pit_rd_n is tied to 1.
//
// Parameters:
//   STROBE_CYC  wr_n/rd_n low pulse width in zclk cycles (2..15)
//   GAP_CYC     cs_n-high cycles between bus cycles (1..15)
//
// Ports:
//   zclk, rst_n           clock, asynchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE)
//   req_op                0 = program channel, 1 = latch-and-read channel
//   req_ch, req_mode      target channel 0..2, counter mode 0..3
//   req_count             16-bit reload value
//   rsp_valid/rsp_err     one-cycle completion pulse, error qualifier
//   rsp_data              last readback value, held until next readback
//   pit_cs_n/wr_n/rd_n    timer bus strobes (active-low)
//   pit_a, pit_dout       timer address {a1,a0} and write data
//   pit_doe               drive enable for pit_dout
//   pit_din               timer read data
module pit_cfg_ctrl #(
    parameter int STROBE_CYC = 2,
    parameter int GAP_CYC    = 1
) (
    input  logic        zclk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [1:0]  req_ch,
    input  logic [2:0]  req_mode,
    input  logic [15:0] req_count,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic        pit_cs_n,
    output logic        pit_wr_n,
    output logic        pit_rd_n,
    output logic [1:0]  pit_a,
    output logic [7:0]  pit_dout,
    output logic        pit_doe,
    input  logic [7:0]  pit_din
);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD,
        GAP,
        RESP
    } state_t;

    localparam logic [3:0] STB_LAST = 4'(STROBE_CYC - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

`ifdef PIT_READBACK_EN
    localparam logic RB_EN = 1'b1;
`else
    localparam logic RB_EN = 1'b0;
`endif

    state_t      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        op_q, op_d;
    logic [1:0]  ch_q, ch_d;
    logic [2:0]  mode_q, mode_d;
    logic [15:0] count_q, count_d;
    logic        err_q, err_d;

    logic        cs_n_q, cs_n_d;
    logic        wr_n_q, wr_n_d;
    logic [1:0]  a_q, a_d;
    logic [7:0]  dout_q, dout_d;
    logic        doe_q, doe_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q, rsp_err_d;

    logic        reject;
    logic        active_d;
    logic        wr_cyc_d;

`ifdef PIT_READBACK_EN
    logic        rd_n_q, rd_n_d;
    logic [15:0] rsp_data_q, rsp_data_d;
    logic [15:0] rd_buf_q, rd_buf_d;
`else
    logic        unused_din;
    assign unused_din = ^pit_din;
`endif

    assign reject = (req_ch == 2'd3) || (!req_op && req_mode[2]) || (req_op && !RB_EN);

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        ch_d    = ch_q;
        mode_d  = mode_q;
        count_d = count_q;
        err_d   = err_q;
`ifdef PIT_READBACK_EN
        rd_buf_d   = rd_buf_q;
        rsp_data_d = rsp_data_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    op_d    = req_op;
                    ch_d    = req_ch;
                    mode_d  = req_mode;
                    count_d = req_count;
                    step_d  = '0;
                    cnt_d   = '0;
                    err_d   = reject;
                    state_d = reject ? RESP : SETUP;
                end
            end
            SETUP: begin
                cnt_d   = '0;
                state_d = STROBE;
            end
            STROBE: begin
                if (cnt_q == STB_LAST) begin
                    state_d = HOLD;
`ifdef PIT_READBACK_EN
                    // rd_n is still low on this edge, so pit_din is valid.
                    if (op_q && step_q == 2'd1) rd_buf_d[7:0]  = pit_din;
                    if (op_q && step_q == 2'd2) rd_buf_d[15:8] = pit_din;
`endif
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                cnt_d   = '0;
                state_d = GAP;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    if (step_q == 2'd2) begin
                        state_d = RESP;
`ifdef PIT_READBACK_EN
                        // Publish only at completion so rsp_data holds the
                        // previous value for the whole transaction.
                        if (op_q) rsp_data_d = rd_buf_q;
`endif
                    end else begin
                        step_d  = step_q + 2'd1;
                        state_d = SETUP;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP: begin
                step_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Bus and response outputs are registered from the next-state view
        // so they change cleanly with the state flops.
        active_d = (state_d == SETUP) || (state_d == STROBE) || (state_d == HOLD);
        wr_cyc_d = (step_d == 2'd0) || !op_d;

        cs_n_d = !active_d;
        wr_n_d = !((state_d == STROBE) && wr_cyc_d);
        doe_d  = active_d && wr_cyc_d;
        a_d    = '0;
        dout_d = '0;
        if (active_d) begin
            a_d = (step_d == 2'd0) ? 2'd3 : ch_d;
            if (wr_cyc_d) begin
                unique case (step_d)
                    2'd0:    dout_d = op_d ? {ch_d, 6'b000000} : {ch_d, 2'b11, mode_d, 1'b0};
                    2'd1:    dout_d = count_d[7:0];
                    default: dout_d = count_d[15:8];
                endcase
            end
        end
`ifdef PIT_READBACK_EN
        rd_n_d = !((state_d == STROBE) && !wr_cyc_d);
`endif

        rsp_valid_d = (state_d == RESP);
        rsp_err_d   = (state_d == RESP) && err_d;
    end

    always_ff @(posedge zclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_q      <= '0;
            cnt_q       <= '0;
            op_q        <= 1'b0;
            ch_q        <= '0;
            mode_q      <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            wr_n_q      <= 1'b1;
            a_q         <= '0;
            dout_q      <= '0;
            doe_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            ch_q        <= ch_d;
            mode_q      <= mode_d;
            count_q     <= count_d;
            err_q       <= err_d;
            cs_n_q      <= cs_n_d;
            wr_n_q      <= wr_n_d;
            a_q         <= a_d;
            dout_q      <= dout_d;
            doe_q       <= doe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef PIT_READBACK_EN
    always_ff @(posedge zclk or negedge rst_n) begin
        if (!rst_n) begin
            rd_n_q     <= 1'b1;
            rsp_data_q <= '0;
            rd_buf_q   <= '0;
        end else begin
            rd_n_q     <= rd_n_d;
            rsp_data_q <= rsp_data_d;
            rd_buf_q   <= rd_buf_d;
        end
    end

    assign pit_rd_n = rd_n_q;
    assign rsp_data = rsp_data_q;
`else
    assign pit_rd_n = 1'b1;
    assign rsp_data = '0;
`endif

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign pit_cs_n  = cs_n_q;
    assign pit_wr_n  = wr_n_q;
    assign pit_a     = a_q;
    assign pit_dout  = dout_q;
    assign pit_doe   = doe_q;

endmodule

// File: tb/tb_pit_cfg_ctrl.sv
// Directed bench for pit_cfg_ctrl with default parameters.
// Write cycles are logged as {pit_a, pit_dout} on the HOLD cycle that
// follows a wr_n pulse; bus invariants are checked on every falling edge.
module tb_pit_cfg_ctrl;

    logic        zclk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_op;
    logic [1:0]  req_ch;
    logic [2:0]  req_mode;
    logic [15:0] req_count;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_data;
    logic        pit_cs_n;
    logic        pit_wr_n;
    logic        pit_rd_n;
    logic [1:0]  pit_a;
    logic [7:0]  pit_dout;
    logic        pit_doe;
    logic [7:0]  pit_din;

    int checks = 0;
    int errors = 0;

    logic [9:0] wlog[$];
    logic       mon_en  = 1'b0;
    logic       prev_wr = 1'b1;
    logic       prev_rd = 1'b1;
    logic       cs_seen = 1'b0;
    int         acc_cnt = 0;
    int         rd_idx  = 0;

    always #5 zclk = ~zclk;

    // Timer model: first read of a sequence returns the LSB, second the MSB.
    assign pit_din = (rd_idx == 0) ? 8'h5A : 8'h00;

    pit_cfg_ctrl #(.STROBE_CYC(2), .GAP_CYC(1)) dut (
        .zclk      (zclk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_ch    (req_ch),
        .req_mode  (req_mode),
        .req_count (req_count),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_data  (rsp_data),
        .pit_cs_n  (pit_cs_n),
        .pit_wr_n  (pit_wr_n),
        .pit_rd_n  (pit_rd_n),
        .pit_a     (pit_a),
        .pit_dout  (pit_dout),
        .pit_doe   (pit_doe),
        .pit_din   (pit_din)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge zclk) begin
        if (mon_en) begin
            chk("wr_rd_excl", {31'd0, (!pit_wr_n && !pit_rd_n)}, 32'd0);
            chk("doe_on_read", {31'd0, (!pit_rd_n && pit_doe)}, 32'd0);
            if (pit_cs_n) chk("idle_addr", {30'd0, pit_a}, 32'd0);
`ifndef PIT_READBACK_EN
            chk("rd_tied", {31'd0, pit_rd_n}, 32'd1);
`endif
            if (!pit_cs_n) cs_seen = 1'b1;
            if (!prev_wr && pit_wr_n && !pit_cs_n) wlog.push_back({pit_a, pit_dout});
            if (!prev_rd && pit_rd_n) rd_idx++;
            if (rst_n && req_valid && req_ready) acc_cnt++;
        end
        prev_wr = pit_wr_n;
        prev_rd = pit_rd_n;
    end

    task automatic chk_writes(input string tag, input int n,
                              input logic [9:0] e0, input logic [9:0] e1, input logic [9:0] e2);
        logic [9:0] e[3];
        e[0] = e0;
        e[1] = e1;
        e[2] = e2;
        chk({tag, "_nwr"}, wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size(); i++)
            chk($sformatf("%s_wr%0d", tag, i), {22'd0, wlog[i]}, {22'd0, e[i]});
    endtask

    // Issue one request; exp_cyc is the cycle (1 = cycle right after the
    // accepting edge) on which rsp_valid must be seen.
    task automatic run_req(input string tag, input logic op, input logic [1:0] ch,
                           input logic [2:0] mode, input logic [15:0] cnt,
                           input int exp_cyc, input logic exp_err, input bit hold);
        int k;
        int acc0;
        wlog.delete();
        cs_seen   = 1'b0;
        acc0      = acc_cnt;
        req_op    = op;
        req_ch    = ch;
        req_mode  = mode;
        req_count = cnt;
        req_valid = 1'b1;
        @(posedge zclk); #1;
        if (!hold) req_valid = 1'b0;
        chk({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
        k = 0;
        while (!rsp_valid && k < 40) begin
            @(posedge zclk); #1;
            k++;
        end
        req_valid = 1'b0;
        chk({tag, "_latency"}, k + 1, exp_cyc);
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
        @(posedge zclk); #1;
        chk({tag, "_rsp_pulse"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_accepts"}, acc_cnt - acc0, 32'd1);
        chk({tag, "_cs_activity"}, {31'd0, cs_seen}, {31'd0, !exp_err});
    endtask

    initial begin
        bit saw_rsp;
        rst_n     = 1'b1;
        req_valid = 1'b0;
        req_op    = 1'b0;
        req_ch    = 2'd0;
        req_mode  = 3'd0;
        req_count = 16'h0000;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_data", {16'd0, rsp_data}, 32'd0);
        chk("rst_cs_n", {31'd0, pit_cs_n}, 32'd1);
        chk("rst_wr_n", {31'd0, pit_wr_n}, 32'd1);
        chk("rst_rd_n", {31'd0, pit_rd_n}, 32'd1);
        chk("rst_a", {30'd0, pit_a}, 32'd0);
        chk("rst_dout", {24'd0, pit_dout}, 32'd0);
        chk("rst_doe", {31'd0, pit_doe}, 32'd0);
        @(posedge zclk); @(posedge zclk); #1;
        rst_n  = 1'b1;
        mon_en = 1'b1;
        @(posedge zclk); #1;

        // Program ch0 mode3 0x1234: control 0x36, then 0x34, 0x12 at a=0.
        run_req("prog0", 1'b0, 2'd0, 3'd3, 16'h1234, 16, 1'b0, 1'b0);
        chk_writes("prog0", 3, {2'd3, 8'h36}, {2'd0, 8'h34}, {2'd0, 8'h12});
        chk("prog0_rsp_data", {16'd0, rsp_data}, 32'd0);

        // Program ch2 mode2 0x0000: control 0xB4.
        run_req("prog2", 1'b0, 2'd2, 3'd2, 16'h0000, 16, 1'b0, 1'b0);
        chk_writes("prog2", 3, {2'd3, 8'hB4}, {2'd2, 8'h00}, {2'd2, 8'h00});

        // Rejections: response on the first cycle, no bus activity.
        run_req("rej_ch3", 1'b0, 2'd3, 3'd0, 16'h1111, 1, 1'b1, 1'b0);
        chk_writes("rej_ch3", 0, 10'd0, 10'd0, 10'd0);
        run_req("rej_mode5", 1'b0, 2'd1, 3'd5, 16'h2222, 1, 1'b1, 1'b0);
        chk_writes("rej_mode5", 0, 10'd0, 10'd0, 10'd0);
`ifndef PIT_READBACK_EN
        run_req("rej_rdbk", 1'b1, 2'd1, 3'd0, 16'h0000, 1, 1'b1, 1'b0);
        chk_writes("rej_rdbk", 0, 10'd0, 10'd0, 10'd0);
        chk("rej_rdbk_data", {16'd0, rsp_data}, 32'd0);
`endif

        // Reset during the first STROBE cycle of step 1.
        wlog.delete();
        req_op    = 1'b0;
        req_ch    = 2'd0;
        req_mode  = 3'd3;
        req_count = 16'h1234;
        req_valid = 1'b1;
        @(posedge zclk); #1;
        req_valid = 1'b0;
        repeat (6) begin
            @(posedge zclk); #1;
        end
        chk("abort_pre_wr_n", {31'd0, pit_wr_n}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", {31'd0, pit_cs_n}, 32'd1);
        chk("abort_wr_n", {31'd0, pit_wr_n}, 32'd1);
        chk("abort_rd_n", {31'd0, pit_rd_n}, 32'd1);
        chk("abort_doe", {31'd0, pit_doe}, 32'd0);
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        @(posedge zclk); #1;
        rst_n = 1'b1;
        saw_rsp = 1'b0;
        repeat (20) begin
            @(posedge zclk); #1;
            if (rsp_valid) saw_rsp = 1'b1;
        end
        chk("abort_no_rsp", {31'd0, saw_rsp}, 32'd0);

        // Program ch1 mode2 0x00FF after the abort: control 0x74.
        run_req("prog1", 1'b0, 2'd1, 3'd2, 16'h00FF, 16, 1'b0, 1'b0);
        chk_writes("prog1", 3, {2'd3, 8'h74}, {2'd1, 8'hFF}, {2'd1, 8'h00});

        // req_valid held high for the whole transaction: one acceptance.
        run_req("hold", 1'b0, 2'd0, 3'd0, 16'hABCD, 16, 1'b0, 1'b1);
        chk_writes("hold", 3, {2'd3, 8'h30}, {2'd0, 8'hCD}, {2'd0, 8'hAB});

`ifdef PIT_READBACK_EN
        // Latch ch1 (control 0x40) and read LSB 0x5A, MSB 0x00.
        rd_idx = 0;
        run_req("rdbk", 1'b1, 2'd1, 3'd0, 16'h0000, 16, 1'b0, 1'b0);
        chk_writes("rdbk", 1, {2'd3, 8'h40}, 10'd0, 10'd0);
        chk("rdbk_reads", rd_idx, 32'd2);
        chk("rdbk_data", {16'd0, rsp_data}, 32'h0000005A);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
